booth_divider: RTL and testbench

- Sequential signed integer divider; the inverse companion to the team's radix-2 Booth multiplier.
- Uses the same init/idle/valid control handshake and the same operand widths, so the datapath controller can swap the two units or run them side by side.
- Computes quotient and remainder with a radix-2 restoring algorithm on operand magnitudes, followed by sign correction.
- Quotient truncates toward zero; the remainder takes the sign of the dividend.

---
 rtl/booth_divider_if.sv | 21 ++
 rtl/booth_divider.sv | 117 +++++++++++
 tb/tb_booth_divider.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/booth_divider_if.sv
// rtl/booth_divider_if.sv - init/idle/valid handshake and operand/result bus for booth_divider
interface booth_divider_if #(parameter int N = 64);
  logic         init;
  logic         idle;
  logic         valid;
  logic [N-1:0] dividend;
  logic [N-1:0] divisor;
  logic [N-1:0] quotient;
  logic [N-1:0] remainder;
  logic         div_by_zero;

  modport master (
    output init, dividend, divisor,
    input  idle, valid, quotient, remainder, div_by_zero
  );

  modport slave (
    input  init, dividend, divisor,
    output idle, valid, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/booth_divider.sv
// rtl/booth_divider.sv - sequential signed radix-2 restoring divider, quotient toward zero
module booth_divider #(
  parameter int N = 64
) (
  input  logic            clk,
  input  logic            reset,
  booth_divider_if.slave  bus
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_PREP = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;
  localparam logic [1:0] S_FIX  = 2'd3;
  localparam int CW = $clog2(N + 1);
  localparam logic [N-1:0] MOST_NEG = {1'b1, {(N-1){1'b0}}};

  logic [1:0]    r_state;
  logic [N-1:0]  r_a;
  logic [N-1:0]  r_b;
  logic          r_sd;
  logic          r_sv;
  logic [N-1:0]  r_q;
  logic [N-1:0]  r_r;
  logic [N-1:0]  r_dmag;
  logic [CW-1:0] r_cnt;
  logic          r_idle;
  logic          r_valid;
  logic [N-1:0]  r_quotient;
  logic [N-1:0]  r_remainder;
  logic          r_dbz;

  // Settled partial remainder is always below |divisor|, so N bits hold it; only the shifted value needs N+1.
  logic [N:0] w_shift_r;
  logic [N:0] w_t;
  assign w_shift_r = {r_r, r_q[N-1]};
  assign w_t       = w_shift_r - {1'b0, r_dmag};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_a         <= '0;
      r_b         <= '0;
      r_sd        <= 1'b0;
      r_sv        <= 1'b0;
      r_q         <= '0;
      r_r         <= '0;
      r_dmag      <= '0;
      r_cnt       <= '0;
      r_idle      <= 1'b1;
      r_valid     <= 1'b0;
      r_quotient  <= '0;
      r_remainder <= '0;
      r_dbz       <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.init) begin
            r_a     <= bus.dividend;
            r_b     <= bus.divisor;
            r_sd    <= bus.dividend[N-1];
            r_sv    <= bus.divisor[N-1];
            r_idle  <= 1'b0;
            r_state <= S_PREP;
          end
        end
        S_PREP: begin
          if (r_b == '0) begin
            r_quotient  <= '1;
            r_remainder <= r_a;
            r_dbz       <= 1'b1;
            r_valid     <= 1'b1;
            r_idle      <= 1'b1;
            r_state     <= S_IDLE;
          end else if (r_a == MOST_NEG && r_b == '1) begin
            r_quotient  <= MOST_NEG;
            r_remainder <= '0;
            r_dbz       <= 1'b0;
            r_valid     <= 1'b1;
            r_idle      <= 1'b1;
            r_state     <= S_IDLE;
          end else begin
            r_q     <= r_sd ? -r_a : r_a;
            r_dmag  <= r_sv ? -r_b : r_b;
            r_r     <= '0;
            r_cnt   <= CW'(N);
            r_state <= S_DIV;
          end
        end
        S_DIV: begin
          if (!w_t[N]) begin
            r_r <= w_t[N-1:0];
            r_q <= {r_q[N-2:0], 1'b1};
          end else begin
            r_r <= w_shift_r[N-1:0];
            r_q <= {r_q[N-2:0], 1'b0};
          end
          r_cnt <= r_cnt - CW'(1);
          if (r_cnt == CW'(1)) r_state <= S_FIX;
        end
        default: begin
          r_quotient  <= (r_sd ^ r_sv) ? -r_q : r_q;
          r_remainder <= r_sd ? -r_r : r_r;
          r_dbz       <= 1'b0;
          r_valid     <= 1'b1;
          r_idle      <= 1'b1;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.idle        = r_idle;
  assign bus.valid       = r_valid;
  assign bus.quotient    = r_quotient;
  assign bus.remainder   = r_remainder;
  assign bus.div_by_zero = r_dbz;
endmodule

// File: tb/tb_booth_divider.sv
// tb/tb_booth_divider.sv - directed scoreboard bench for booth_divider at N=8 and N=64
module tb_booth_divider;
  logic clk;
  logic reset;
  int   total;
  int   bad;

  booth_divider_if #(.N(8))  bus8 ();
  booth_divider_if #(.N(64)) bus64 ();

  booth_divider #(.N(8))  dut8  (.clk(clk), .reset(reset), .bus(bus8.slave));
  booth_divider #(.N(64)) dut64 (.clk(clk), .reset(reset), .bus(bus64.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] q;
    logic [7:0] r;
    logic       dbz;
  } res8_t;

  typedef struct packed {
    logic [63:0] q;
    logic [63:0] r;
  } res64_t;

  res8_t  sb8[$];
  res64_t sb64[$];

  function automatic res8_t model8(input logic signed [7:0] a, input logic signed [7:0] b);
    res8_t e;
    if (b == 8'sd0) begin
      e.q = 8'hFF; e.r = a; e.dbz = 1'b1;
    end else if (a == 8'h80 && b == 8'hFF) begin
      e.q = 8'h80; e.r = 8'h00; e.dbz = 1'b0;
    end else begin
      e.q = a / b; e.r = a % b; e.dbz = 1'b0;
    end
    return e;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; init is seen by the next rising edge, which is the accept edge.
  task automatic drive8(input logic [7:0] a, input logic [7:0] b, input bit score);
    bus8.init     = 1'b1;
    bus8.dividend = a;
    bus8.divisor  = b;
    if (score) sb8.push_back(model8(a, b));
    @(negedge clk);
    bus8.init = 1'b0;
  endtask

  task automatic wait8(input int exp_lat, input string tag);
    int    lat;
    res8_t e;
    lat = 0;
    while (bus8.valid !== 1'b1 && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    chk({tag, "_sb_nonempty"}, 64'(sb8.size() != 0), 64'd1);
    if (sb8.size() != 0) begin
      e = sb8.pop_front();
      chk({tag, "_q"}, 64'(bus8.quotient), 64'(e.q));
      chk({tag, "_r"}, 64'(bus8.remainder), 64'(e.r));
      chk({tag, "_dbz"}, 64'(bus8.div_by_zero), 64'(e.dbz));
    end
    chk({tag, "_idle"}, 64'(bus8.idle), 64'd1);
  endtask

  logic [7:0]  ta [3];
  logic [7:0]  tb_ [3];
  logic signed [63:0] sa;
  logic signed [63:0] sb;
  res64_t e64;
  logic [63:0] cap_q;
  logic [63:0] cap_r;
  int nv;
  int vlat;

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1;
    bus8.init = 1'b0;  bus8.dividend = '0;  bus8.divisor = '0;
    bus64.init = 1'b0; bus64.dividend = '0; bus64.divisor = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst8_idle", 64'(bus8.idle), 64'd1);
    chk("rst8_valid", 64'(bus8.valid), 64'd0);
    chk("rst8_q", 64'(bus8.quotient), 64'd0);
    chk("rst8_r", 64'(bus8.remainder), 64'd0);
    chk("rst8_dbz", 64'(bus8.div_by_zero), 64'd0);
    chk("rst64_idle", 64'(bus64.idle), 64'd1);
    chk("rst64_q", bus64.quotient, 64'd0);

    drive8(8'd100, 8'd7, 1'b1);
    wait8(10, "p100_7");
    @(negedge clk);
    chk("pulse_drop", 64'(bus8.valid), 64'd0);
    chk("hold_q", 64'(bus8.quotient), 64'd14);
    chk("hold_r", 64'(bus8.remainder), 64'd2);

    ta  = '{8'h9C, 8'd100, 8'h9C};
    tb_ = '{8'd7,  8'hF9,  8'hF9};
    for (int i = 0; i < 3; i++) begin
      drive8(ta[i], tb_[i], 1'b1);
      wait8(10, $sformatf("sign%0d", i));
      @(negedge clk);
    end

    drive8(8'd5, 8'd0, 1'b1);
    wait8(1, "div0");
    @(negedge clk);
    drive8(8'h80, 8'hFF, 1'b1);
    wait8(1, "ovf");
    @(negedge clk);

    drive8(8'd100, 8'd7, 1'b1);
    wait8(10, "b2b_first");
    drive8(8'd50, 8'd6, 1'b1);
    wait8(10, "b2b_second");
    chk("b2b_q_const", 64'(bus8.quotient), 64'd8);
    @(negedge clk);

    drive8(8'd100, 8'd7, 1'b0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("midrst_idle", 64'(bus8.idle), 64'd1);
    chk("midrst_valid", 64'(bus8.valid), 64'd0);
    chk("midrst_q", 64'(bus8.quotient), 64'd0);
    chk("midrst_r", 64'(bus8.remainder), 64'd0);
    nv = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus8.valid === 1'b1) nv++;
    end
    chk("midrst_no_valid", 64'(nv), 64'd0);
    drive8(8'd100, 8'd7, 1'b1);
    wait8(10, "after_rst");
    @(negedge clk);

    sa = 64'sh7FFF_FFFF_FFFF_FFFF;
    sb = 64'sd3;
    e64.q = sa / sb;
    e64.r = sa % sb;
    sb64.push_back(e64);
    bus64.init = 1'b1; bus64.dividend = sa; bus64.divisor = sb;
    @(negedge clk);
    bus64.init = 1'b0;
    nv = 0; vlat = -1; cap_q = '0; cap_r = '0;
    for (int i = 1; i <= 100; i++) begin
      if (i == 5) begin
        bus64.init = 1'b1; bus64.dividend = 64'd1000; bus64.divisor = 64'd10;
      end
      if (i == 6) bus64.init = 1'b0;
      @(negedge clk);
      if (bus64.valid === 1'b1) begin
        nv++;
        vlat = i;
        cap_q = bus64.quotient;
        cap_r = bus64.remainder;
      end
    end
    chk("n64_valid_count", 64'(nv), 64'd1);
    chk("n64_latency", 64'(vlat), 64'd66);
    chk("n64_sb_nonempty", 64'(sb64.size() != 0), 64'd1);
    if (sb64.size() != 0) begin
      e64 = sb64.pop_front();
      chk("n64_q", cap_q, e64.q);
      chk("n64_r", cap_r, e64.r);
    end
    chk("n64_q_const", bus64.quotient, 64'h2AAA_AAAA_AAAA_AAAA);
    chk("n64_dbz", 64'(bus64.div_by_zero), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
